// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between processor (p_*) and host loader (h_*).
// Optional bounded-hold fairness is enabled by defining MEM_ARB_HOLD_EN.
module mem_bus_arbiter #(
   parameter int AW       = 9,
   parameter int DW       = 9,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          p_req,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   input  logic          p_we,
   output logic          p_gnt,
   output logic          p_rvalid,
   output logic [DW-1:0] p_rdata,
   input  logic          h_req,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   input  logic          h_we,
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic [DW-1:0] h_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner
);

   // Handshake: a requester holds req until gnt; a transfer happens in every
   // cycle where req && gnt, and a still-high req next cycle is a new request.

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_P = 2'b01,
      OWN_H = 2'b10
   } state_t;

   if (MAX_HOLD < 1) begin : g_bad_max_hold
      $error("MAX_HOLD must be at least 1");
   end

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_last;          // 1: host was granted last
   logic          w_p_gnt;
   logic          w_h_gnt;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_mem_we;
   logic          r_tag_vld;
   logic          r_tag_host;
   logic          r_p_rvalid;
   logic          r_h_rvalid;

`ifdef MEM_ARB_HOLD_EN
   localparam int            HW    = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] MAX_C = HW'(MAX_HOLD);
   logic [HW-1:0] r_hold;
   logic [HW-1:0] w_hold_nxt;
   logic [HW-1:0] w_hold_inc;

   assign w_hold_inc = (r_hold == MAX_C) ? r_hold : r_hold + HW'(1);
`endif

   always_comb begin
      w_p_gnt = 1'b0;
      w_h_gnt = 1'b0;
`ifdef MEM_ARB_HOLD_EN
      w_hold_nxt = '0;
`endif
      if (p_req && h_req) begin
`ifdef MEM_ARB_HOLD_EN
         if (r_state == IDLE) begin
            w_p_gnt    = r_last;
            w_h_gnt    = !r_last;
            w_hold_nxt = HW'(1);
         end else if (r_hold < MAX_C) begin
            w_p_gnt    = (r_state == OWN_P);
            w_h_gnt    = (r_state == OWN_H);
            w_hold_nxt = w_hold_inc;
         end else begin
            w_p_gnt    = (r_state == OWN_H);
            w_h_gnt    = (r_state == OWN_P);
            w_hold_nxt = HW'(1);
         end
`else
         w_p_gnt = r_last;
         w_h_gnt = !r_last;
`endif
      end else if (p_req) begin
         w_p_gnt = 1'b1;
`ifdef MEM_ARB_HOLD_EN
         w_hold_nxt = (r_state == OWN_P) ? w_hold_inc : HW'(1);
`endif
      end else if (h_req) begin
         w_h_gnt = 1'b1;
`ifdef MEM_ARB_HOLD_EN
         w_hold_nxt = (r_state == OWN_H) ? w_hold_inc : HW'(1);
`endif
      end
   end

   always_comb begin
      w_state_nxt = IDLE;
      if (w_p_gnt)      w_state_nxt = OWN_P;
      else if (w_h_gnt) w_state_nxt = OWN_H;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_last      <= 1'b1;
`ifdef MEM_ARB_HOLD_EN
         r_hold      <= '0;
`endif
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_tag_vld   <= 1'b0;
         r_tag_host  <= 1'b0;
         r_p_rvalid  <= 1'b0;
         r_h_rvalid  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
`ifdef MEM_ARB_HOLD_EN
         r_hold  <= w_hold_nxt;
`endif
         if (w_p_gnt || w_h_gnt) r_last <= w_h_gnt;
         if (w_p_gnt) begin
            r_mem_addr  <= p_addr;
            r_mem_wdata <= p_wdata;
            r_mem_we    <= p_we;
         end else if (w_h_gnt) begin
            r_mem_addr  <= h_addr;
            r_mem_wdata <= h_wdata;
            r_mem_we    <= h_we;
         end else begin
            r_mem_we <= 1'b0;
         end
         // Read tag travels alongside mem_addr, then becomes rvalid as RAM data lands
         r_tag_vld  <= (w_p_gnt && !p_we) || (w_h_gnt && !h_we);
         r_tag_host <= w_h_gnt;
         r_p_rvalid <= r_tag_vld && !r_tag_host;
         r_h_rvalid <= r_tag_vld && r_tag_host;
      end
   end

   assign p_gnt     = w_p_gnt;
   assign h_gnt     = w_h_gnt;
   assign p_rvalid  = r_p_rvalid;
   assign h_rvalid  = r_h_rvalid;
   assign p_rdata   = mem_rdata;
   assign h_rdata   = mem_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_we    = r_mem_we;
   assign owner     = r_state;

endmodule
